// File: rtl/consecutive_bits_detector.sv
// Serial run detector: flags the bit that completes RUN_LEN consecutive MATCH_BIT samples.
// Optional saturating detection counter when CONSEC_DET_COUNT_EN is defined.
module consecutive_bits_detector #(
  parameter int   RUN_LEN   = 3,
  parameter int   OVERLAP   = 1,
  parameter logic MATCH_BIT = 1'b1,
  parameter int   CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       c,
  output logic                       d,
  output logic [$clog2(RUN_LEN)-1:0] run_cnt
`ifdef CONSEC_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]           det_cnt,
  output logic                       det_sat
`endif
);

  localparam int RW = $clog2(RUN_LEN);
  localparam logic [RW-1:0] LAST = RW'(RUN_LEN - 1);

  if (RUN_LEN < 2) begin : g_bad_run_len
    $error("consecutive_bits_detector: RUN_LEN must be 2 or more");
  end

  logic          match;
  logic          unreach;
  logic [RW-1:0] run_nxt;

  assign match   = (c == MATCH_BIT);
  assign unreach = (32'(run_cnt) >= 32'(RUN_LEN));
  assign d       = reset && en && !clr && match && (run_cnt == LAST);

  always_comb begin
    run_nxt = run_cnt;
    if (clr) begin
      run_nxt = '0;
    end else if (en) begin
      if (unreach || !match) begin
        run_nxt = '0;
      end else if (run_cnt == LAST) begin
        run_nxt = (OVERLAP != 0) ? LAST : '0;
      end else begin
        run_nxt = run_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_nxt;
    end
  end

`ifdef CONSEC_DET_COUNT_EN
  // Saturating detection counter; holds at all-ones instead of wrapping.
  logic [CNT_W-1:0] det_nxt;

  assign det_sat = (det_cnt == '1);

  always_comb begin
    det_nxt = det_cnt;
    if (clr) begin
      det_nxt = '0;
    end else if (d && !det_sat) begin
      det_nxt = det_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_cnt <= '0;
    end else begin
      det_cnt <= det_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_consecutive_bits_detector.sv
// Directed bench for consecutive_bits_detector across several parameter sets.
// Counter checks are active only when CONSEC_DET_COUNT_EN is defined.
module tb_consecutive_bits_detector;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic c = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // a: RUN_LEN=3 overlap; b: RUN_LEN=3 non-overlap; x: RUN_LEN=4 overlap;
  // s: RUN_LEN=3 overlap CNT_W=2; z: RUN_LEN=2 non-overlap, MATCH_BIT=0
  logic       d_a, d_b, d_x, d_s, d_z;
  logic [1:0] rc_a, rc_b, rc_x, rc_s;
  logic [0:0] rc_z;
`ifdef CONSEC_DET_COUNT_EN
  logic [7:0] dc_a, dc_b, dc_x, dc_z;
  logic [1:0] dc_s;
  logic       ds_a, ds_b, ds_x, ds_s, ds_z;
`endif

  consecutive_bits_detector #(.RUN_LEN(3), .OVERLAP(1), .MATCH_BIT(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .c(c), .d(d_a), .run_cnt(rc_a)
`ifdef CONSEC_DET_COUNT_EN
    , .det_cnt(dc_a), .det_sat(ds_a)
`endif
  );

  consecutive_bits_detector #(.RUN_LEN(3), .OVERLAP(0), .MATCH_BIT(1'b1), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .c(c), .d(d_b), .run_cnt(rc_b)
`ifdef CONSEC_DET_COUNT_EN
    , .det_cnt(dc_b), .det_sat(ds_b)
`endif
  );

  consecutive_bits_detector #(.RUN_LEN(4), .OVERLAP(1), .MATCH_BIT(1'b1), .CNT_W(8)) u_x (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .c(c), .d(d_x), .run_cnt(rc_x)
`ifdef CONSEC_DET_COUNT_EN
    , .det_cnt(dc_x), .det_sat(ds_x)
`endif
  );

  consecutive_bits_detector #(.RUN_LEN(3), .OVERLAP(1), .MATCH_BIT(1'b1), .CNT_W(2)) u_s (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .c(c), .d(d_s), .run_cnt(rc_s)
`ifdef CONSEC_DET_COUNT_EN
    , .det_cnt(dc_s), .det_sat(ds_s)
`endif
  );

  consecutive_bits_detector #(.RUN_LEN(2), .OVERLAP(0), .MATCH_BIT(1'b0), .CNT_W(8)) u_z (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .c(c), .d(d_z), .run_cnt(rc_z)
`ifdef CONSEC_DET_COUNT_EN
    , .det_cnt(dc_z), .det_sat(ds_z)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic apply(input logic e, input logic cl, input logic b);
    @(negedge clk);
    en = e; clr = cl; c = b;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b0; clr = 1'b0; c = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_da[6]  = '{0, 0, 1, 1, 1, 1};
    int exp_ra[6]  = '{0, 1, 2, 2, 2, 2};
    int exp_db[6]  = '{0, 0, 1, 0, 0, 1};
    int exp_rb[6]  = '{0, 1, 2, 0, 1, 2};
    int exp_dx[6]  = '{0, 0, 0, 1, 1, 1};
    int exp_rx[6]  = '{0, 1, 2, 3, 3, 3};
    logic in30[7]  = '{1, 1, 0, 1, 1, 1, 1};
    int r30[7]     = '{0, 1, 2, 0, 1, 2, 3};
    int d30[7]     = '{0, 0, 0, 0, 0, 0, 1};
    logic inz[4]   = '{0, 0, 0, 1};
    int dz[4]      = '{0, 1, 0, 0};
    int rz[4]      = '{0, 1, 0, 1};

    // Reset held with a matching stream driven: everything stays cleared.
    en = 1'b1; c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rc_a", rc_a, 0);
    check("rst_d_a", d_a, 0);
    check("rst_rc_x", rc_x, 0);
    check("rst_d_b", d_b, 0);
`ifdef CONSEC_DET_COUNT_EN
    check("rst_dc_a", dc_a, 0);
    check("rst_ds_s", ds_s, 0);
`endif
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;

    // Six ones: overlap vs non-overlap vs longer run.
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b0, 1'b1);
      check($sformatf("ones_d_a[%0d]", i), d_a, exp_da[i]);
      check($sformatf("ones_rc_a[%0d]", i), rc_a, exp_ra[i]);
      check($sformatf("ones_d_b[%0d]", i), d_b, exp_db[i]);
      check($sformatf("ones_rc_b[%0d]", i), rc_b, exp_rb[i]);
      check($sformatf("ones_d_x[%0d]", i), d_x, exp_dx[i]);
      check($sformatf("ones_rc_x[%0d]", i), rc_x, exp_rx[i]);
    end
    apply(1'b0, 1'b0, 1'b1);
    check("hold_d_a", d_a, 0);
    check("hold_rc_a", rc_a, 2);
    check("hold_d_z", d_z, 0);
`ifdef CONSEC_DET_COUNT_EN
    check("ones_dc_a", dc_a, 4);
    check("ones_dc_b", dc_b, 2);
    check("ones_dc_x", dc_x, 3);
    check("ones_dc_s", dc_s, 3);
    check("ones_ds_s", ds_s, 1);
    check("ones_ds_a", ds_a, 0);
    check("ones_dc_z", dc_z, 0);
`endif

    // Run of four with an interrupting zero.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b0, in30[i]);
      check($sformatf("r4_rc_x[%0d]", i), rc_x, r30[i]);
      check($sformatf("r4_d_x[%0d]", i), d_x, d30[i]);
    end

    // Enable gap: state holds, c ignored.
    do_reset();
    apply(1'b1, 1'b0, 1'b1);
    check("en_rc0", rc_a, 0);
    apply(1'b0, 1'b0, 1'b0);
    check("en_rc1", rc_a, 1);
    check("en_d1", d_a, 0);
    apply(1'b1, 1'b0, 1'b1);
    check("en_rc2", rc_a, 1);
    check("en_d2", d_a, 0);
    apply(1'b1, 1'b0, 1'b1);
    check("en_rc3", rc_a, 2);
    check("en_d3", d_a, 1);
    apply(1'b0, 1'b0, 1'b1);
    check("en_off_rc", rc_a, 2);
    check("en_off_d", d_a, 0);

    // Asynchronous reset mid-run, then synchronous clear.
    do_reset();
    apply(1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("pre_arst_rc", rc_a, 2);
    check("pre_arst_d", d_a, 1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_rc", rc_a, 0);
    check("arst_d", d_a, 0);
    #1;
    reset = 1'b1;
    apply(1'b1, 1'b0, 1'b1);
    check("post_arst_rc", rc_a, 0);
    check("post_arst_d", d_a, 0);
    apply(1'b1, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b1);
    check("preclr_d", d_a, 1);
    apply(1'b1, 1'b1, 1'b1);
    check("clr_d", d_a, 0);
    check("clr_rc", rc_a, 2);
`ifdef CONSEC_DET_COUNT_EN
    check("preclr_dc", dc_a, 1);
`endif
    apply(1'b1, 1'b0, 1'b1);
    check("postclr_rc", rc_a, 0);
    check("postclr_d", d_a, 0);
`ifdef CONSEC_DET_COUNT_EN
    check("postclr_dc", dc_a, 0);
`endif

    // Counter saturation with CNT_W=2 over eight ones.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b1);
`ifdef CONSEC_DET_COUNT_EN
      if (i == 4) begin
        check("sat_mid_dc", dc_s, 2);
        check("sat_mid_ds", ds_s, 0);
      end
`endif
    end
    check("sat_d_s", d_s, 1);
    apply(1'b0, 1'b0, 1'b0);
`ifdef CONSEC_DET_COUNT_EN
    check("sat_dc", dc_s, 3);
    check("sat_ds", ds_s, 1);
`endif

    // MATCH_BIT=0, RUN_LEN=2, non-overlapping.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, inz[i]);
      check($sformatf("z_d[%0d]", i), d_z, dz[i]);
      check($sformatf("z_rc[%0d]", i), rc_z, rz[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/consecutive_bits_detector.md
CONSECUTIVE_BITS_DETECTOR -- requirements
Module: consecutive_bits_detector

Interface
REQ-001 Parameter RUN_LEN, default 3: run length to detect; SHALL be legal only for values of 2 or more.
REQ-002 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-003 Parameter MATCH_BIT, default 1'b1: bit value that counts toward a run.
REQ-004 Parameter CNT_W, default 8: width of the detection counter.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; reset=0 SHALL clear all state immediately.
REQ-007 en  input  1  sample qualifier; c is consumed only in cycles where en=1.
REQ-008 clr  input  1  synchronous clear of run and detection state.
REQ-009 c  input  1  serial data bit.
REQ-010 d  output  1  Mealy detect output, combinational from state, c, en and clr.
REQ-011 run_cnt  output  $clog2(RUN_LEN)  registered count of consecutive matches already seen.
REQ-012 det_cnt  output  CNT_W  saturating count of detections (present only when the Configuration macro is defined).
REQ-013 det_sat  output  1  high while det_cnt is at its all-ones value (present only when the Configuration macro is defined).

Function
REQ-014 The state SHALL be run_cnt, ranging over 0..RUN_LEN-1; run_cnt is the number of trailing MATCH_BIT samples.
REQ-015 d SHALL equal (en && !clr && c==MATCH_BIT && run_cnt==RUN_LEN-1); detection has zero cycles of latency in the same cycle as the completing bit.
REQ-016 When en=1, clr=0 and c!=MATCH_BIT, run_cnt SHALL go to 0 at the next edge.
REQ-017 When en=1, clr=0, c==MATCH_BIT and run_cnt<RUN_LEN-1, run_cnt SHALL increment by 1.
REQ-018 When en=1, clr=0, c==MATCH_BIT and run_cnt==RUN_LEN-1, the next run_cnt SHALL be RUN_LEN-1 if OVERLAP=1 and 0 if OVERLAP=0.
REQ-019 When en=0 and clr=0, run_cnt SHALL hold its value, and d SHALL be 0 regardless of c.
REQ-020 When clr=1, run_cnt SHALL go to 0 at the next edge, d SHALL be 0 in that cycle, and det_cnt SHALL go to 0; clr SHALL take priority over en.
REQ-021 Every cycle with d=1 SHALL increment det_cnt by 1 at the next edge, saturating at 2^CNT_W-1 with no wrap-around.
REQ-022 det_sat SHALL be registered-consistent with det_cnt, i.e. it is a pure decode of det_cnt==all-ones.
REQ-023 Unreachable run_cnt encodings (values of RUN_LEN or above) SHALL recover to 0 at the next enabled edge.

Reset
REQ-024 While reset=0, run_cnt SHALL be 0, det_cnt SHALL be 0, det_sat SHALL be 0 and d SHALL be 0, asynchronously and independent of clk.
REQ-025 After reset deasserts, the first sample accepted SHALL be the one at the first rising edge with en=1; a run interrupted by reset mid-sequence SHALL restart from 0.

Configuration
REQ-026 Macro CONSEC_DET_COUNT_EN: when it is defined, det_cnt, det_sat and their logic SHALL be compiled in per REQ-012, REQ-013, REQ-021 and REQ-022.
REQ-027 When CONSEC_DET_COUNT_EN is undefined, the det_cnt and det_sat ports and their logic SHALL be absent, and d and run_cnt behaviour SHALL be identical to the macro-defined build.

Verification
REQ-028 RUN_LEN=3, OVERLAP=1, en=1, c=1,1,1,1,1 -> d=0,0,1,1,1; run_cnt=0,1,2,2,2 before each edge.
REQ-029 RUN_LEN=3, OVERLAP=0, en=1, c=1,1,1,1,1,1 -> d=0,0,1,0,0,1; det_cnt ends at 2.
REQ-030 RUN_LEN=4, c=1,1,0,1,1,1,1 with en=1 -> d high only on the 7th bit; run_cnt returns to 0 after the 0.
REQ-031 RUN_LEN=3, c=1,1,1 with en=0 on the 2nd cycle (c=0 in that cycle) -> run_cnt holds at 1 and d=1 on the 4th cycle.
REQ-032 RUN_LEN=3, c=1,1, then reset pulsed low mid-cycle, then c=1 -> run_cnt=0 asynchronously and d=0 on the third 1; clr=1 with c=1 at run_cnt=2 -> d=0 and run_cnt goes to 0.
REQ-033 CONSEC_DET_COUNT_EN defined, CNT_W=2, OVERLAP=1, c held at 1 for 8 cycles -> det_cnt=3 with det_sat=1 and no wrap to 0.
